// File: rtl/imm_decode_ctrl.sv
// Two-slot decode sequencer between the IFU and the EXU: stage A drives the
// sign-extension unit, stage B holds instr/pc/immediate for the EXU.
module imm_decode_ctrl #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [ILEN-1:0] sext_instr,
  output logic [2:0]      sext_sel,
  input  logic [XLEN-1:0] sext_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_sel,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_I    = 3'd1,
    SEL_U    = 3'd2,
    SEL_S    = 3'd3,
    SEL_J    = 3'd4,
    SEL_B    = 3'd5
  } imm_sel_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  // Stage A: instruction currently presented to the sign-extension unit
  logic            a_valid_q, a_valid_d;
  logic [ILEN-1:0] a_instr_q, a_instr_d;
  logic [XLEN-1:0] a_pc_q,    a_pc_d;

  // Stage B: decoded instruction presented to the EXU
  logic            b_valid_q,   b_valid_d;
  logic [ILEN-1:0] b_instr_q,   b_instr_d;
  logic [XLEN-1:0] b_pc_q,      b_pc_d;
  logic [XLEN-1:0] b_imm_q,     b_imm_d;
  imm_sel_e        b_sel_q,     b_sel_d;
  logic            b_illegal_q, b_illegal_d;

  imm_sel_e dec_sel;
  logic     dec_illegal;
  logic     b_ready;
  logic     a_move;
  logic     accept;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    dec_sel     = SEL_NONE;
    dec_illegal = 1'b0;
    unique case (a_instr_q[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: dec_sel = SEL_I;
      OP_LUI, OP_AUIPC:                              dec_sel = SEL_U;
      OP_STORE:                                      dec_sel = SEL_S;
      OP_JAL:                                        dec_sel = SEL_J;
      OP_BRANCH:                                     dec_sel = SEL_B;
      OP_REG, OP_REG32:                              dec_sel = SEL_NONE;
      default:                                       dec_illegal = 1'b1;
    endcase
  end

  assign b_ready  = !b_valid_q || out_ready;
  assign in_ready = (!a_valid_q || b_ready) && !flush;
  assign a_move   = a_valid_q && b_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    a_valid_d   = a_valid_q;
    a_instr_d   = a_instr_q;
    a_pc_d      = a_pc_q;
    b_valid_d   = b_valid_q;
    b_instr_d   = b_instr_q;
    b_pc_d      = b_pc_q;
    b_imm_d     = b_imm_q;
    b_sel_d     = b_sel_q;
    b_illegal_d = b_illegal_q;

    if (flush) begin
      // Data registers keep stale contents; only the valids are killed.
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end else begin
      if (a_move) begin
        b_valid_d   = 1'b1;
        b_instr_d   = a_instr_q;
        b_pc_d      = a_pc_q;
        // Instructions without an immediate (R-type, illegal) carry zero.
        b_imm_d     = (dec_sel == SEL_NONE) ? '0 : sext_imm;
        b_sel_d     = dec_sel;
        b_illegal_d = dec_illegal;
      end else if (out_ready) begin
        b_valid_d = 1'b0;
      end

      if (accept) begin
        a_valid_d = 1'b1;
        a_instr_d = in_instr;
        a_pc_d    = in_pc;
      end else if (a_move) begin
        a_valid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every register
  // samples the pre-edge values; data registers are reset too so the outputs
  // read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q   <= 1'b0;
      a_instr_q   <= '0;
      a_pc_q      <= '0;
      b_valid_q   <= 1'b0;
      b_instr_q   <= '0;
      b_pc_q      <= '0;
      b_imm_q     <= '0;
      b_sel_q     <= SEL_NONE;
      b_illegal_q <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_instr_q   <= a_instr_d;
      a_pc_q      <= a_pc_d;
      b_valid_q   <= b_valid_d;
      b_instr_q   <= b_instr_d;
      b_pc_q      <= b_pc_d;
      b_imm_q     <= b_imm_d;
      b_sel_q     <= b_sel_d;
      b_illegal_q <= b_illegal_d;
    end
  end

  assign sext_instr  = a_instr_q;
  assign sext_sel    = a_valid_q ? dec_sel : SEL_NONE;
  assign out_valid   = b_valid_q;
  assign out_instr   = b_instr_q;
  assign out_pc      = b_pc_q;
  assign out_imm     = b_imm_q;
  assign out_imm_sel = b_sel_q;
  assign out_illegal = b_valid_q && b_illegal_q;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Self-checking bench for imm_decode_ctrl: directed scenarios followed by random
// traffic, compared against a queue-based reference model.
module tb_imm_decode_ctrl;
  localparam int XLEN = 64;
  localparam int ILEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [ILEN-1:0] in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic [ILEN-1:0] sext_instr;
  logic [2:0]      sext_sel;
  logic [XLEN-1:0] sext_imm;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_imm_sel;
  logic            out_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_decode_ctrl #(.XLEN(XLEN), .ILEN(ILEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .sext_instr(sext_instr), .sext_sel(sext_sel), .sext_imm(sext_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_imm(out_imm), .out_imm_sel(out_imm_sel),
    .out_illegal(out_illegal)
  );

  // Sign-extension unit the DUT talks to (bit-field concatenation form).
  function automatic logic [63:0] sext_unit(input logic [31:0] i, input logic [2:0] sel);
    case (sel)
      3'd1:    return {{52{i[31]}}, i[31:20]};
      3'd2:    return {{32{i[31]}}, i[31:12], 12'b0};
      3'd3:    return {{52{i[31]}}, i[31:25], i[11:7]};
      3'd4:    return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd5:    return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return '0;
    endcase
  endfunction
  assign sext_imm = sext_unit(sext_instr, sext_sel);

  // Reference model: opcode table plus arithmetic immediate extraction.
  int sel_of[int];

  function automatic int model_sel(input logic [31:0] i);
    return sel_of.exists(int'(i[6:0])) ? sel_of[int'(i[6:0])] : 0;
  endfunction

  function automatic bit model_illegal(input logic [31:0] i);
    return !sel_of.exists(int'(i[6:0]));
  endfunction

  function automatic logic [63:0] model_imm(input logic [31:0] i);
    longint s;
    s = longint'($signed(i));
    case (model_sel(i))
      1: return s >>> 20;
      2: return (s >>> 12) << 12;
      3: return ((s >>> 25) << 5) | longint'(i[11:7]);
      4: return ((s >>> 31) << 20) | (longint'(i[19:12]) << 12) |
                (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
      5: return ((s >>> 31) << 12) | (longint'(i[7]) << 11) |
                (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
      default: return 64'd0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    int          acc;
  } item_t;

  item_t q[$];
  int    ecount = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // An accepted item becomes visible to the EXU one edge after it was taken.
  function automatic bit model_out_valid();
    return (q.size() > 0) && (ecount >= q[0].acc + 1);
  endfunction

  task automatic compare_outputs();
    bit    ov;
    bit    a_full;
    item_t a;
    ov = model_out_valid();
    check("out_valid", out_valid, ov);
    if (ov) begin
      check("out_instr",   out_instr,   q[0].instr);
      check("out_pc",      out_pc,      q[0].pc);
      check("out_imm_sel", out_imm_sel, model_sel(q[0].instr));
      check("out_imm",     out_imm,     model_imm(q[0].instr));
      check("out_illegal", out_illegal, model_illegal(q[0].instr));
    end
    a_full = 1'b0;
    if (q.size() == 2) begin
      a = q[1]; a_full = 1'b1;
    end else if (q.size() == 1 && !ov) begin
      a = q[0]; a_full = 1'b1;
    end
    if (a_full) begin
      check("sext_instr", sext_instr, a.instr);
      check("sext_sel",   sext_sel,   model_sel(a.instr));
    end else begin
      check("sext_sel_idle", sext_sel, 0);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check in_ready,
  // then advance the model at the edge. Entered and left at a negedge.
  task automatic cycle(input bit fl, input bit iv, input logic [31:0] ins,
                       input logic [63:0] pc, input bit ordy);
    bit ov;
    bit rdy_exp;
    compare_outputs();
    flush = fl; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
    #1;
    ov      = model_out_valid();
    rdy_exp = (q.size() < 2 || ordy) && !fl;
    check("in_ready", in_ready, rdy_exp);
    @(posedge clk);
    ecount++;
    if (fl) begin
      q.delete();
    end else begin
      if (ov && ordy) void'(q.pop_front());
      if (iv && rdy_exp) q.push_back('{instr: ins, pc: pc, acc: ecount});
    end
    @(negedge clk);
  endtask

  logic [31:0] stream_ins [3];
  logic [63:0] stream_imm [3];
  logic [2:0]  stream_sel [3];
  logic [6:0]  opc_pool   [15];

  initial begin
    sel_of[7'h03] = 1; sel_of[7'h13] = 1; sel_of[7'h1B] = 1; sel_of[7'h67] = 1; sel_of[7'h73] = 1;
    sel_of[7'h37] = 2; sel_of[7'h17] = 2;
    sel_of[7'h23] = 3;
    sel_of[7'h6F] = 4;
    sel_of[7'h63] = 5;
    sel_of[7'h33] = 0; sel_of[7'h3B] = 0;

    opc_pool = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h37, 7'h17, 7'h23,
                 7'h6F, 7'h63, 7'h33, 7'h3B, 7'h00, 7'h0F, 7'h7F};
    stream_ins = '{32'h800000B7, 32'h0080006F, 32'hFE000EE3};
    stream_imm = '{64'hFFFFFFFF80000000, 64'h8, 64'hFFFFFFFFFFFFFFFC};
    stream_sel = '{3'd2, 3'd4, 3'd5};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_imm",   out_imm, 0);
    check("rst_out_pc",    out_pc, 0);
    check("rst_sext_sel",  sext_sel, 0);
    check("rst_sext_instr", sext_instr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single addi x1,x0,-1
    cycle(0, 1, 32'hFFF00093, 64'h1000, 1);
    cycle(0, 0, 32'h0, 64'h0, 1);
    check("addi_valid",   out_valid, 1);
    check("addi_sel",     out_imm_sel, 1);
    check("addi_imm",     out_imm, 64'hFFFFFFFFFFFFFFFF);
    check("addi_illegal", out_illegal, 0);
    cycle(0, 0, 32'h0, 64'h0, 1);

    // Back-to-back lui/jal/beq with out_ready high
    for (int k = 0; k < 5; k++) begin
      cycle(0, k < 3, (k < 3) ? stream_ins[k % 3] : 32'h0, 64'h2000 + 64'(4 * k), 1);
      if (k >= 1 && k <= 3) begin
        check("stream_valid", out_valid, 1);
        check("stream_sel",   out_imm_sel, stream_sel[k - 1]);
        check("stream_imm",   out_imm, stream_imm[k - 1]);
      end
    end

    // Backpressure: three offered, two taken, outputs hold, then drain in order
    for (int k = 0; k < 3; k++) cycle(0, 1, stream_ins[k], 64'h3000 + 64'(4 * k), 0);
    check("bp_in_ready", in_ready, 0);
    repeat (3) cycle(0, 0, 32'h0, 64'h0, 0);
    check("bp_hold_pc", out_pc, 64'h3000);
    cycle(0, 1, stream_ins[2], 64'h3008, 1);
    repeat (4) cycle(0, 0, 32'h0, 64'h0, 1);

    // Flush with both stages full and in_valid high
    cycle(0, 1, 32'hFFF00093, 64'h4000, 0);
    cycle(0, 1, 32'h0080006F, 64'h4004, 0);
    cycle(1, 1, 32'hFE000EE3, 64'h4008, 1);
    check("flush_out_valid", out_valid, 0);
    cycle(0, 1, 32'h800000B7, 64'h400C, 1);
    cycle(0, 0, 32'h0, 64'h0, 1);
    check("post_flush_pc", out_pc, 64'h400C);
    cycle(1, 0, 32'h0, 64'h0, 1);
    cycle(1, 0, 32'h0, 64'h0, 0);

    // Illegal all-zero word and R-type add
    cycle(0, 1, 32'h00000000, 64'h5000, 1);
    cycle(0, 1, 32'h002081B3, 64'h5004, 1);
    check("illegal_flag", out_illegal, 1);
    check("illegal_sel",  out_imm_sel, 0);
    check("illegal_imm",  out_imm, 0);
    cycle(0, 0, 32'h0, 64'h0, 1);
    check("add_flag", out_illegal, 0);
    check("add_sel",  out_imm_sel, 0);
    check("add_imm",  out_imm, 0);
    cycle(0, 0, 32'h0, 64'h0, 1);

    // Asynchronous reset while out_valid is high
    cycle(0, 1, 32'hFFF00093, 64'h6000, 0);
    cycle(0, 1, 32'h0080006F, 64'h6004, 0);
    check("pre_rst_valid", out_valid, 1);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] ins;
      ins = {$urandom_range(32'h1FFFFFF, 0), opc_pool[$urandom_range(14, 0)]};
      cycle($urandom_range(99, 0) < 6, $urandom_range(99, 0) < 75, ins,
            {$urandom, $urandom}, $urandom_range(99, 0) < 60);
    end
    repeat (4) cycle(0, 0, 32'h0, 64'h0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
